// File: rtl/acumulador_multicanal_if.sv
// Operation/result bundle for acumulador_multicanal.
// The master drives operations and the slave returns registered results.
interface acumulador_multicanal_if #(
    parameter int N  = 25,
    parameter int CH = 4,
    parameter int CW = 8
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic signed [2*N-1:0] In;
    logic [SW-1:0]         ch_sel;
    logic [1:0]            mode;
    logic                  in_valid;

    logic signed [2*N-1:0] Acumulado;
    logic [SW-1:0]         out_ch;
    logic                  out_valid;
    logic                  changed;
    logic                  sat;
    logic [CW-1:0]         count;
    logic                  err_ch;

    modport master (
        output In, ch_sel, mode, in_valid,
        input  Acumulado, out_ch, out_valid, changed, sat, count, err_ch
    );

    modport slave (
        input  In, ch_sel, mode, in_valid,
        output Acumulado, out_ch, out_valid, changed, sat, count, err_ch
    );
endinterface

// File: rtl/acumulador_multicanal.sv
// Multi-channel signed saturating accumulator with per-channel sticky
// saturation flag and saturating operation count; results registered by one cycle.
module acumulador_multicanal #(
    parameter int N  = 25,
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    acumulador_multicanal_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [W-1:0] MAX_V   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V   = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0]       CNT_MAX = {CW{1'b1}};

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_LOAD  = 2'b01;
    localparam logic [1:0] M_ACC   = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic signed [W-1:0] val_q [CH];
    logic [CW-1:0]       cnt_q [CH];
    logic [CH-1:0]       sat_q;

    logic signed [W-1:0] acc_q;
    logic [SW-1:0]       och_q;
    logic                ovalid_q;
    logic                chg_q;
    logic                sat_out_q;
    logic [CW-1:0]       cnt_out_q;
    logic                err_q;

    logic                sel_ok;
    logic signed [W-1:0] cur_val;
    logic [CW-1:0]       cur_cnt;
    logic                cur_sat;

    logic signed [W:0]   sum_ext;
    logic signed [W-1:0] nxt_val;
    logic [CW-1:0]       nxt_cnt;
    logic                nxt_sat;

    // Channel lookup by compare rather than indexing, so an out-of-range
    // ch_sel never reads past the end of the arrays.
    always_comb begin
        sel_ok  = 1'b0;
        cur_val = '0;
        cur_cnt = '0;
        cur_sat = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (bus.ch_sel == SW'(i)) begin
                sel_ok  = 1'b1;
                cur_val = val_q[i];
                cur_cnt = cnt_q[i];
                cur_sat = sat_q[i];
            end
        end
    end

    assign sum_ext = {cur_val[W-1], cur_val} + {bus.In[W-1], bus.In};

    always_comb begin
        nxt_val = cur_val;
        nxt_cnt = cur_cnt;
        nxt_sat = cur_sat;
        case (bus.mode)
            M_LOAD: begin
                nxt_val = bus.In;
                nxt_cnt = CW'(1);
                nxt_sat = 1'b0;
            end
            M_ACC: begin
                // Top two sum bits disagree exactly when the result left the W-bit range.
                if (sum_ext[W] != sum_ext[W-1]) begin
                    nxt_val = sum_ext[W] ? MIN_V : MAX_V;
                    nxt_sat = 1'b1;
                end else begin
                    nxt_val = sum_ext[W-1:0];
                end
                nxt_cnt = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CW'(1);
            end
            M_CLEAR: begin
                nxt_val = '0;
                nxt_cnt = '0;
                nxt_sat = 1'b0;
            end
            M_HOLD: begin
                nxt_val = cur_val;
            end
            default: begin
                nxt_val = cur_val;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                val_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            sat_q     <= '0;
            acc_q     <= '0;
            och_q     <= '0;
            ovalid_q  <= 1'b0;
            chg_q     <= 1'b0;
            sat_out_q <= 1'b0;
            cnt_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ovalid_q <= 1'b0;
            err_q    <= 1'b0;
            if (bus.in_valid) begin
                if (sel_ok) begin
                    for (int i = 0; i < CH; i++) begin
                        if (bus.ch_sel == SW'(i)) begin
                            val_q[i] <= nxt_val;
                            cnt_q[i] <= nxt_cnt;
                            sat_q[i] <= nxt_sat;
                        end
                    end
                    acc_q     <= nxt_val;
                    och_q     <= bus.ch_sel;
                    ovalid_q  <= 1'b1;
                    chg_q     <= (nxt_val != cur_val);
                    sat_out_q <= nxt_sat;
                    cnt_out_q <= nxt_cnt;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Acumulado = acc_q;
    assign bus.out_ch    = och_q;
    assign bus.out_valid = ovalid_q;
    assign bus.changed   = chg_q;
    assign bus.sat       = sat_out_q;
    assign bus.count     = cnt_out_q;
    assign bus.err_ch    = err_q;
endmodule

// File: tb/tb_acumulador_multicanal.sv
// Directed-vector bench for acumulador_multicanal (N=4, CH=3, CW=3).
module tb_acumulador_multicanal;
    logic clk;
    logic rst_n;

    acumulador_multicanal_if #(.N(4), .CH(3), .CW(3)) bus ();

    acumulador_multicanal #(.N(4), .CH(3), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] ch;
        logic [7:0] din;
        logic       vld;
        logic [7:0] e_acc;
        logic [1:0] e_ch;
        logic       e_v;
        logic       e_chg;
        logic       e_sat;
        logic [2:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int mode, int ch, int din, int vld, int acc, int och,
                                int ov, int chg, int st, int cnt, int er);
        vec_t v;
        v.mode  = 2'(mode);
        v.ch    = 2'(ch);
        v.din   = 8'(din);
        v.vld   = 1'(vld);
        v.e_acc = 8'(acc);
        v.e_ch  = 2'(och);
        v.e_v   = 1'(ov);
        v.e_chg = 1'(chg);
        v.e_sat = 1'(st);
        v.e_cnt = 3'(cnt);
        v.e_err = 1'(er);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, vec_t v);
        chk({tag, " Acumulado"}, {24'h0, bus.Acumulado}, {24'h0, v.e_acc});
        chk({tag, " out_ch"},    {30'h0, bus.out_ch},    {30'h0, v.e_ch});
        chk({tag, " out_valid"}, {31'h0, bus.out_valid}, {31'h0, v.e_v});
        chk({tag, " changed"},   {31'h0, bus.changed},   {31'h0, v.e_chg});
        chk({tag, " sat"},       {31'h0, bus.sat},       {31'h0, v.e_sat});
        chk({tag, " count"},     {29'h0, bus.count},     {29'h0, v.e_cnt});
        chk({tag, " err_ch"},    {31'h0, bus.err_ch},    {31'h0, v.e_err});
    endtask

    task automatic apply(string tag, vec_t v);
        @(negedge clk);
        bus.mode     = v.mode;
        bus.ch_sel   = v.ch;
        bus.In       = v.din;
        bus.in_valid = v.vld;
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // mode, ch, in, vld | acc, out_ch, out_valid, changed, sat, count, err
        vecs.push_back(mk(0, 0,    0, 1,    0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1,   10, 1,   10, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(2, 1,    5, 1,   15, 1, 1, 1, 0, 2, 0));
        vecs.push_back(mk(2, 1,  -20, 1,   -5, 1, 1, 1, 0, 3, 0));
        vecs.push_back(mk(1, 0,  100, 1,  100, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(2, 0,   50, 1,  127, 0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(2, 0,   -7, 1,  120, 0, 1, 1, 1, 3, 0));
        vecs.push_back(mk(3, 0,    0, 1,    0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, -100, 1, -100, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(2, 0, -100, 1, -128, 0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(3, 2,    0, 1,    0, 2, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(2, 2, 1, 1, k, 2, 1, 1, 0, (k > 7) ? 7 : k, 0));
        vecs.push_back(mk(2, 0,    3, 1, -125, 0, 1, 1, 1, 3, 0));
        vecs.push_back(mk(2, 1,    2, 1,   -3, 1, 1, 1, 0, 4, 0));
        vecs.push_back(mk(2, 0,    3, 1, -122, 0, 1, 1, 1, 4, 0));
        vecs.push_back(mk(2, 1,    2, 1,   -1, 1, 1, 1, 0, 5, 0));
        vecs.push_back(mk(0, 1,    0, 1,   -1, 1, 1, 0, 0, 5, 0));
        vecs.push_back(mk(2, 1,    0, 1,   -1, 1, 1, 0, 0, 6, 0));
        // bad channel, then idle: registered outputs other than the strobes stay put
        vecs.push_back(mk(2, 3,    5, 1,   -1, 1, 0, 0, 0, 6, 1));
        vecs.push_back(mk(0, 0,    0, 0,   -1, 1, 0, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0,    0, 1, -122, 0, 1, 0, 1, 4, 0));
        vecs.push_back(mk(0, 1,    0, 1,   -1, 1, 1, 0, 0, 6, 0));
        vecs.push_back(mk(0, 2,    0, 1,    9, 2, 1, 0, 0, 7, 0));
        // exact range limits: reaching the bound is not saturation, passing it is
        vecs.push_back(mk(2, 2,  118, 1,  127, 2, 1, 1, 0, 7, 0));
        vecs.push_back(mk(2, 2,    1, 1,  127, 2, 1, 0, 1, 7, 0));
        vecs.push_back(mk(2, 1, -127, 1, -128, 1, 1, 1, 0, 7, 0));

        rst_n        = 1'b0;
        bus.In       = '0;
        bus.ch_sel   = '0;
        bus.mode     = 2'b00;
        bus.in_valid = 1'b0;
        #1;
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // asynchronous reset right after a result appears must wipe it at once
        apply("preload", mk(1, 1, 5, 1, 5, 1, 1, 1, 0, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst_ch0", mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        apply("post_rst_ch1", mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0));

        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acumulador_multicanal.md
# acumulador_multicanal

Parametrised multi-channel signed accumulator for the 2N-bit fixed-point products coming out of the multiplier stage. It keeps CH independent accumulator channels and applies one operation per accepted input: hold/read, load, saturating accumulate or clear. Each channel also tracks a saturation flag and an operation count. The result of every accepted operation is presented registered, one cycle later, for the downstream normalisation/output stage.

## Interface
- N, 25, half data width; data path is 2N bits, two's complement
- CH, 4, number of channels (≥1)
- CW, 8, width of per-channel accumulate counter
- SW, $clog2(CH) (min 1), width of channel select (derived)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- In  in  2N  signed operand
- ch_sel  in  SW  target channel
- mode  in  2  00 hold/read, 01 load, 10 accumulate, 11 clear
- in_valid  in  1  operation strobe; one operation accepted per cycle when high
- Acumulado  out  2N  resulting value of the addressed channel
- out_ch  out  SW  channel the output belongs to
- out_valid  out  1  one-cycle pulse: Acumulado/out_ch/flags valid
- changed  out  1  new channel value differs from its previous value
- sat  out  1  sticky saturation flag of the addressed channel
- count  out  CW  accumulate count of the addressed channel
- err_ch  out  1  one-cycle pulse: ch_sel ≥ CH on an in_valid cycle

## Operation
- Reset (rst_n low, asynchronous): all channel values 0, all counts 0, all sticky sat 0, Acumulado 0, out_ch 0, out_valid 0, changed 0, sat 0, count 0, err_ch 0. Held while rst_n low; operation resumes on the first rising edge after release.
- in_valid low: no channel state changes; out_valid 0, err_ch 0; other outputs keep their last values.
- ch_sel ≥ CH with in_valid high: no channel state changes; err_ch 1 for one cycle, out_valid 0.
- Valid op on channel c, old value A, count K, flag S:
  - hold (00): value A, count K, flag S unchanged (read-back).
  - load (01): value In, count 1, flag 0.
  - clear (11): value 0, count 0, flag 0.
  - accumulate (10): form the full 2N+1-bit sum A+In. Above 2^(2N-1)-1, the value is 2^(2N-1)-1 and the flag is set. Below -2^(2N-1), the value is -2^(2N-1) and the flag is set. Otherwise the value is the sum and the flag is S. The count is K+1, saturating at 2^CW-1 with no wrap.
- Outputs for a valid op: Acumulado = new value; out_ch = c; sat = new flag; count = new count. changed = (new value ≠ A); it is 0 for hold and for an accumulate of 0.
- Channels not addressed are never modified.
- The sticky flag clears only on load, clear or reset. It is not cleared by a later accumulate that does not overflow.

## Timing
- Latency 1: an op accepted at edge k updates channel state at edge k. Outputs show the result during cycle k+1.
- out_valid and err_ch are high for exactly one cycle per accepted op. There is no backpressure.
- Back-to-back ops on the same channel every cycle are fully supported; each op sees the previous op's result with no hazard.
- Back-to-back ops on different channels are independent.
- rst_n asserted mid-stream discards any in-flight result; out_valid drops immediately, without waiting for a clock edge.

## Test plan
- Use N=4 (8-bit), CH=3, CW=3.
- Reset: assert rst_n=0 mid-run → all outputs 0 immediately. After release, hold on ch0 → Acumulado 0, count 0, changed 0.
- Load/accumulate: load 10 on ch1, then accumulate +5 and -20 → Acumulado 10, 15, -5 on consecutive cycles; count 1, 2, 3; changed 1 each time.
- Saturation: load 100 on ch0, accumulate +50 → 127, sat 1. Accumulate -7 → 120, sat stays 1. Clear → 0, sat 0. Load -100, accumulate -100 → -128, sat 1.
- Count saturation: clear ch2, then 9 accumulates of +1 → count 1..7, then stays 7; value reaches 9.
- Isolation/interleave: alternate ch0/ch1 accumulates every cycle → each channel's sum is independent; out_ch tracks the channel. Hold on ch1 returns its value with changed 0.
- Bad channel: ch_sel=3 with accumulate → err_ch pulse, out_valid 0. Subsequent reads of ch0..ch2 are unchanged.
